// File: rtl/uart_loader.sv
// uart_loader: boot-time program loader from an 8N1 UART line into CPU memory.
// It receives a 16-bit little-endian word count N and then N little-endian
// 16-bit words. Words are written upward from LOAD_BASE while the CPU is held
// in reset. The CPU is released once the last word has been written.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx         UART receive line (idle high, asynchronous to clk)
//   mem_addr   byte address of the current write (holds between strobes)
//   wr_mem     one-cycle write strobe
//   wr_data    word to write (holds between strobes)
//   byt        constant 0; only word writes are issued
//   cpu_rst    CPU reset, high while loading
//   loading    high from reset until the load completes
//   frame_err  sticky; set when a byte arrives with stop bit = 0
module uart_loader #(
  parameter int unsigned           CLOCK_HZ   = 27_000_000,
  parameter int unsigned           BAUD       = 115200,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = 'h0300
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  wr_mem,
  output logic [15:0]           wr_data,
  output logic                  byt,
  output logic                  cpu_rst,
  output logic                  loading,
  output logic                  frame_err
);

  localparam int unsigned DIV  = CLOCK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(DIV) + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {HDR_LO, HDR_HI, W_LO, W_HI, DONE} ld_state_e;

  // Receiver state
  logic            r_rx_meta, r_rx_sync;
  rx_state_e       r_rx_state, w_rx_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_bit_idx, w_bit_idx_d;
  logic [7:0]      r_shift, w_shift_d;
  logic            r_byte_valid, w_byte_valid_d;
  logic            r_frame_err, w_frame_err_d;

  // Loader state
  ld_state_e             r_ld_state, w_ld_state_d;
  logic [7:0]            r_n_lo, w_n_lo_d;
  logic [15:0]           r_n, w_n_d;
  logic [15:0]           r_idx, w_idx_d;
  logic [7:0]            r_lo, w_lo_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [15:0]           r_data, w_data_d;
  logic                  r_wr, w_wr_d;
  logic                  r_loading, w_loading_d;

  logic w_active;
  // Once the image is in, the line is ignored entirely (no bytes, no frame errors).
  assign w_active = (r_ld_state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_state   <= w_rx_state_d;
      r_cnt        <= w_cnt_d;
      r_bit_idx    <= w_bit_idx_d;
      r_shift      <= w_shift_d;
      r_byte_valid <= w_byte_valid_d;
      r_frame_err  <= w_frame_err_d;
    end
  end

  always_comb begin
    w_rx_state_d   = r_rx_state;
    w_cnt_d        = r_cnt + 1'b1;
    w_bit_idx_d    = r_bit_idx;
    w_shift_d      = r_shift;
    w_byte_valid_d = 1'b0;
    w_frame_err_d  = r_frame_err;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_cnt_d = '0;
        if (!r_rx_sync && w_active) w_rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start-bit resample rejects short glitches.
        if (r_cnt == CntW'(DIV / 2)) begin
          w_cnt_d      = '0;
          w_bit_idx_d  = '0;
          w_rx_state_d = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == CntW'(DIV - 1)) begin
          w_cnt_d     = '0;
          w_shift_d   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_d = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Sampled mid stop bit, leaving half a bit of slack for a following start edge.
        if (r_cnt == CntW'(DIV - 1)) begin
          w_cnt_d      = '0;
          w_rx_state_d = RX_IDLE;
          if (r_rx_sync) w_byte_valid_d = 1'b1;
          else           w_frame_err_d  = 1'b1;
        end
      end
      default: w_rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_state <= HDR_LO;
      r_n_lo     <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_lo       <= '0;
      r_addr     <= LOAD_BASE;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_loading  <= 1'b1;
    end else begin
      r_ld_state <= w_ld_state_d;
      r_n_lo     <= w_n_lo_d;
      r_n        <= w_n_d;
      r_idx      <= w_idx_d;
      r_lo       <= w_lo_d;
      r_addr     <= w_addr_d;
      r_data     <= w_data_d;
      r_wr       <= w_wr_d;
      r_loading  <= w_loading_d;
    end
  end

  always_comb begin
    w_ld_state_d = r_ld_state;
    w_n_lo_d     = r_n_lo;
    w_n_d        = r_n;
    w_idx_d      = r_idx;
    w_lo_d       = r_lo;
    w_addr_d     = r_addr;
    w_data_d     = r_data;
    w_wr_d       = 1'b0;
    w_loading_d  = r_loading;
    if (r_byte_valid) begin
      unique case (r_ld_state)
        HDR_LO: begin
          w_n_lo_d     = r_shift;
          w_ld_state_d = HDR_HI;
        end
        HDR_HI: begin
          w_n_d   = {r_shift, r_n_lo};
          w_idx_d = '0;
          if ({r_shift, r_n_lo} == 16'd0) begin
            w_ld_state_d = DONE;
            w_loading_d  = 1'b0;
          end else begin
            w_ld_state_d = W_LO;
          end
        end
        W_LO: begin
          w_lo_d       = r_shift;
          w_ld_state_d = W_HI;
        end
        W_HI: begin
          w_wr_d   = 1'b1;
          w_data_d = {r_shift, r_lo};
          // Address wraps silently at the top of the address space.
          w_addr_d = LOAD_BASE + ADDR_WIDTH'({r_idx, 1'b0});
          w_idx_d  = r_idx + 16'd1;
          w_ld_state_d = (r_idx == r_n - 16'd1) ? DONE : W_LO;
        end
        default: ;
      endcase
    end
    // Release the CPU on the cycle after the final write strobe.
    if (r_wr && r_ld_state == DONE) w_loading_d = 1'b0;
  end

  assign mem_addr  = r_addr;
  assign wr_mem    = r_wr;
  assign wr_data   = r_data;
  assign byt       = 1'b0;
  assign cpu_rst   = r_loading;
  assign loading   = r_loading;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;

  localparam int Div = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] mem_addr;
  logic        wr_mem;
  logic [15:0] wr_data;
  logic        byt;
  logic        cpu_rst;
  logic        loading;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  uart_loader #(
    .CLOCK_HZ  (1000),
    .BAUD      (100),
    .ADDR_WIDTH(16),
    .LOAD_BASE (16'h0300)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .mem_addr (mem_addr),
    .wr_mem   (wr_mem),
    .wr_data  (wr_data),
    .byt      (byt),
    .cpu_rst  (cpu_rst),
    .loading  (loading),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          cyc          = 0;
  int          last_wr_cyc  = -1;
  int          cpu_fall_cyc = -1;
  int          wr_running   = 0;
  logic        prev_cpu     = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (wr_mem === 1'b1) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(wr_data);
        last_wr_cyc = cyc;
        if (cpu_rst !== 1'b1) wr_running = wr_running + 1;
      end
      if (prev_cpu === 1'b1 && cpu_rst === 1'b0) cpu_fall_cyc = cyc;
      prev_cpu = cpu_rst;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
    last_wr_cyc  = -1;
    cpu_fall_cyc = -1;
    wr_running   = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Div) @(negedge clk);
    end
    rx = stop_bit;
    repeat (Div) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_loaded(input string name);
    int n;
    n = 0;
    while (loading === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (loading !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: loading=%b required 0 within 300 cycles", name, loading);
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (150) @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1) begin
      failures++; $display("FAIL reset_cpu_rst: got %b required 1", cpu_rst);
    end
    checks++;
    if (loading !== 1'b1) begin
      failures++; $display("FAIL reset_loading: got %b required 1", loading);
    end
    checks++;
    if (mem_addr !== 16'h0300) begin
      failures++; $display("FAIL reset_mem_addr: got %h required 0300", mem_addr);
    end
    checks++;
    if (wr_data !== 16'h0000 || byt !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: wr_data=%h byt=%b frame_err=%b required 0000 0 0",
               wr_data, byt, frame_err);
    end
    checks++;
    if (wa_q.size() != 0) begin
      failures++; $display("FAIL reset_no_write: got %0d writes required 0", wa_q.size());
    end
  endtask

  task automatic test_load();
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h70, 1'b1);
    wait_loaded("load");
    repeat (5) @(negedge clk);
    checks++;
    if (wa_q.size() != 2) begin
      failures++; $display("FAIL load_count: got %0d writes required 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 16'h0300 || wd_q[0] !== 16'h80A5) begin
        failures++;
        $display("FAIL load_w0: got %h@%h required 80a5@0300", wd_q[0], wa_q[0]);
      end
      checks++;
      if (wa_q[1] !== 16'h0302 || wd_q[1] !== 16'h7004) begin
        failures++;
        $display("FAIL load_w1: got %h@%h required 7004@0302", wd_q[1], wa_q[1]);
      end
    end
    checks++;
    if (cpu_fall_cyc != last_wr_cyc + 1) begin
      failures++;
      $display("FAIL load_release_timing: cpu_rst fell at %0d, required %0d",
               cpu_fall_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (cpu_rst !== 1'b0 || wr_running != 0) begin
      failures++;
      $display("FAIL load_cpu_run: cpu_rst=%b writes_while_running=%0d required 0 0",
               cpu_rst, wr_running);
    end
    checks++;
    if (mem_addr !== 16'h0302 || wr_data !== 16'h7004) begin
      failures++;
      $display("FAIL load_hold: got %h@%h required 7004@0302", wr_data, mem_addr);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_loaded("zero");
    checks++;
    if (cpu_rst !== 1'b0 || cpu_fall_cyc < 0) begin
      failures++; $display("FAIL zero_release: cpu_rst=%b required 0", cpu_rst);
    end
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (30) @(negedge clk);
    checks++;
    if (wa_q.size() != 0 || cpu_rst !== 1'b0) begin
      failures++;
      $display("FAIL zero_ignore: got %0d writes cpu_rst=%b required 0 writes cpu_rst=0",
               wa_q.size(), cpu_rst);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h34, 1'b1);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL ferr_before: got %b required 0", frame_err);
    end
    send_byte(8'h99, 1'b0);
    repeat (2 * Div) @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || wa_q.size() != 0) begin
      failures++;
      $display("FAIL ferr_set: frame_err=%b writes=%0d required 1 0", frame_err, wa_q.size());
    end
    send_byte(8'h12, 1'b1);
    wait_loaded("ferr");
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() != 1) begin
      failures++; $display("FAIL ferr_count: got %0d writes required 1", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 16'h0300 || wd_q[0] !== 16'h1234) begin
        failures++;
        $display("FAIL ferr_word: got %h@%h required 1234@0300", wd_q[0], wa_q[0]);
      end
    end
    checks++;
    if (frame_err !== 1'b1) begin
      failures++; $display("FAIL ferr_sticky: got %b required 1", frame_err);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    checks++;
    if (frame_err !== 1'b0 || wa_q.size() != 0 || loading !== 1'b1) begin
      failures++;
      $display("FAIL glitch_idle: frame_err=%b writes=%0d loading=%b required 0 0 1",
               frame_err, wa_q.size(), loading);
    end
    // Loader must still be expecting the header's low byte.
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hAB, 1'b1);
    wait_loaded("glitch");
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 16'h0300 || wd_q[0] !== 16'hABCD) begin
      failures++;
      $display("FAIL glitch_load: writes=%0d first=%h@%h required 1 abcd@0300",
               wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 16'hxxxx,
               (wa_q.size() > 0) ? wa_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1 || loading !== 1'b1 || mem_addr !== 16'h0300 || wr_mem !== 1'b0) begin
      failures++;
      $display("FAIL midrst_values: cpu_rst=%b loading=%b addr=%h wr=%b required 1 1 0300 0",
               cpu_rst, loading, mem_addr, wr_mem);
    end
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_loaded("midrst");
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() != 2) begin
      failures++; $display("FAIL midrst_count: got %0d writes required 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 16'h0300 || wd_q[0] !== 16'h2211 ||
          wa_q[1] !== 16'h0302 || wd_q[1] !== 16'h4433) begin
        failures++;
        $display("FAIL midrst_words: got %h@%h %h@%h required 2211@0300 4433@0302",
                 wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_load();
    test_zero_len();
    test_frame_err();
    test_glitch();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
